mii_tx_framer: RTL

MII 100BASE-T transmit framer: accepts an Ethernet frame (destination MAC through payload) as a byte stream and drives the PHY MII TX pins. Generates preamble and SFD, pads to minimum frame size, appends FCS (CRC-32), and enforces the inter-frame gap. Sits between the MAC/packet-builder logic (ARP/ICMP/UDP responders) and `o_phy_port0_tx_d`/`o_phy_port0_tx_en`, clocked by the PHY TX clock (25 MHz).

---
 rtl/verilog_ethernet_pack.sv | 28 ++
 rtl/eth_crc32_d8.sv | 24 ++
 rtl/mii_tx_framer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/verilog_ethernet_pack.sv
// Shared Ethernet types and constants for the MII transmit/receive path.
package verilog_ethernet_pack;

    typedef logic [7:0] octet_t;

    localparam int unsigned ETH_PREAMBLE_NIBBLES = 15;
    localparam octet_t      ETH_SFD              = 8'hD5;
    localparam logic [31:0] ETH_CRC32_POLY       = 32'hEDB88320;
    localparam logic [31:0] ETH_CRC32_INIT       = 32'hFFFFFFFF;
    localparam int unsigned ETH_MIN_FRAME_OCTETS = 60;
    localparam int unsigned ETH_IFG_OCTETS       = 12;

    typedef enum logic [2:0] {
        StIdle,
        StPreamble,
        StData,
        StPad,
        StFcs,
        StIfg,
        StDrain
    } tx_state_e;

    // 11-bit octet counter that sticks at its maximum instead of wrapping.
    function automatic logic [10:0] sat_inc11(input logic [10:0] v);
        return (v == 11'h7FF) ? v : v + 11'd1;
    endfunction

endpackage

// File: rtl/eth_crc32_d8.sv
// Combinational CRC-32 (reflected) update by one octet, LSB of the octet first.
module eth_crc32_d8
    import verilog_ethernet_pack::*;
(
    input  logic [31:0] crc_i,
    input  octet_t      data_i,
    output logic [31:0] crc_o
);

    logic [31:0] crc_v;

    always_comb begin
        crc_v = crc_i;
        for (int i = 0; i < 8; i++) begin
            if (crc_v[0] ^ data_i[i]) begin
                crc_v = (crc_v >> 1) ^ ETH_CRC32_POLY;
            end else begin
                crc_v = crc_v >> 1;
            end
        end
        crc_o = crc_v;
    end

endmodule

// File: rtl/mii_tx_framer.sv
// MII 100BASE-T transmit framer: preamble/SFD, byte-to-nibble, padding, FCS and
// inter-frame gap, with underflow abort signalled on TX_ER.
module mii_tx_framer
    import verilog_ethernet_pack::*;
#(
    parameter int unsigned p_MIN_FRAME_OCTETS = ETH_MIN_FRAME_OCTETS,
    parameter int unsigned p_IFG_OCTETS       = ETH_IFG_OCTETS
) (
    input  logic       i_clock,
    input  logic       i_reset_n,
    input  octet_t     i_tx_data,
    input  logic       i_tx_valid,
    input  logic       i_tx_last,
    output logic       o_tx_ready,
    output logic [3:0] o_mii_tx_d,
    output logic       o_mii_tx_en,
    output logic       o_mii_tx_er,
    output logic       o_busy,
    output logic       o_frame_done,
    output logic       o_underflow
);

    localparam int unsigned IfgCycles = 2 * p_IFG_OCTETS;
    localparam int unsigned CntW      = (IfgCycles > 16) ? $clog2(IfgCycles) : 4;

    localparam logic [CntW-1:0] PreLast   = CntW'(ETH_PREAMBLE_NIBBLES);
    localparam logic [CntW-1:0] FcsLast   = CntW'(7);
    localparam logic [CntW-1:0] DrainWait = CntW'(2);
    localparam logic [CntW-1:0] IfgLast   = CntW'(IfgCycles - 1);
    localparam logic [10:0]     MinOctets = 11'(p_MIN_FRAME_OCTETS);
    // Preamble octets are 0x55, so every preamble nibble equals the SFD low nibble.
    localparam logic [3:0]      PreNib    = ETH_SFD[3:0];
    localparam logic [3:0]      SfdNib    = ETH_SFD[7:4];

    tx_state_e       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            phase_q, phase_d;
    octet_t          byte_q, byte_d;
    logic            last_q, last_d;
    logic [10:0]     octets_q, octets_d;
    logic [31:0]     crc_q, crc_d, crc_next, fcs;
    logic [3:0]      tx_d_q, tx_d_d;
    logic            tx_en_q, tx_en_d, tx_er_q, tx_er_d;
    logic            done_q, done_d, uflow_q, uflow_d;
    logic            tx_ready;
    octet_t          crc_in;
    logic [2:0]      fcs_idx;

    always_comb begin
        tx_ready = 1'b0;
        case (state_q)
            StPreamble: tx_ready = (cnt_q == PreLast);
            StData:     tx_ready = phase_q & ~last_q;
            StDrain:    tx_ready = (cnt_q == DrainWait);
            default:    tx_ready = 1'b0;
        endcase
    end

    // Pad octets feed zeros into the CRC; accepted bytes feed the input.
    assign crc_in  = tx_ready ? i_tx_data : 8'h00;
    assign fcs     = ~crc_q;
    assign fcs_idx = cnt_q[2:0] + 3'd1;

    eth_crc32_d8 u_crc (
        .crc_i  (crc_q),
        .data_i (crc_in),
        .crc_o  (crc_next)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        phase_d  = phase_q;
        byte_d   = byte_q;
        last_d   = last_q;
        octets_d = octets_q;
        crc_d    = crc_q;
        tx_d_d   = 4'h0;
        tx_en_d  = 1'b0;
        tx_er_d  = 1'b0;
        done_d   = 1'b0;
        uflow_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (i_tx_valid) begin
                    state_d  = StPreamble;
                    cnt_d    = '0;
                    octets_d = '0;
                    crc_d    = ETH_CRC32_INIT;
                    tx_en_d  = 1'b1;
                    tx_d_d   = PreNib;
                end
            end
            StPreamble, StData: begin
                tx_en_d = 1'b1;
                if (state_q == StPreamble && cnt_q != PreLast) begin
                    cnt_d  = cnt_q + CntW'(1);
                    tx_d_d = (cnt_q == PreLast - CntW'(1)) ? SfdNib : PreNib;
                end else if (state_q == StData && !phase_q) begin
                    phase_d = 1'b1;
                    tx_d_d  = byte_q[7:4];
                end else if (tx_ready && i_tx_valid) begin
                    state_d  = StData;
                    phase_d  = 1'b0;
                    byte_d   = i_tx_data;
                    last_d   = i_tx_last;
                    octets_d = sat_inc11(octets_q);
                    crc_d    = crc_next;
                    tx_d_d   = i_tx_data[3:0];
                end else if (tx_ready) begin
                    state_d = StDrain;
                    cnt_d   = '0;
                    tx_er_d = 1'b1;
                    uflow_d = 1'b1;
                end else if (octets_q < MinOctets) begin
                    state_d  = StPad;
                    phase_d  = 1'b0;
                    octets_d = octets_q + 11'd1;
                    crc_d    = crc_next;
                end else begin
                    state_d = StFcs;
                    cnt_d   = '0;
                    tx_d_d  = fcs[3:0];
                end
            end
            StPad: begin
                tx_en_d = 1'b1;
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else if (octets_q < MinOctets) begin
                    phase_d  = 1'b0;
                    octets_d = octets_q + 11'd1;
                    crc_d    = crc_next;
                end else begin
                    state_d = StFcs;
                    cnt_d   = '0;
                    tx_d_d  = fcs[3:0];
                end
            end
            StFcs: begin
                if (cnt_q == FcsLast) begin
                    state_d = StIfg;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CntW'(1);
                    tx_en_d = 1'b1;
                    tx_d_d  = fcs[{fcs_idx, 2'b00} +: 4];
                    done_d  = (fcs_idx == 3'd7);
                end
            end
            StIfg: begin
                if (cnt_q == IfgLast) begin
                    crc_d = ETH_CRC32_INIT;
                    // A waiting frame starts straight away so the gap is exactly IfgCycles.
                    if (i_tx_valid) begin
                        state_d  = StPreamble;
                        cnt_d    = '0;
                        octets_d = '0;
                        tx_en_d  = 1'b1;
                        tx_d_d   = PreNib;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDrain: begin
                if (cnt_q == '0) begin
                    cnt_d   = CntW'(1);
                    tx_en_d = 1'b1;
                    tx_er_d = 1'b1;
                end else if (cnt_q != DrainWait) begin
                    cnt_d = DrainWait;
                end else if (i_tx_valid && i_tx_last) begin
                    state_d = StIfg;
                    cnt_d   = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            phase_q  <= 1'b0;
            byte_q   <= '0;
            last_q   <= 1'b0;
            octets_q <= '0;
            crc_q    <= ETH_CRC32_INIT;
            tx_d_q   <= '0;
            tx_en_q  <= 1'b0;
            tx_er_q  <= 1'b0;
            done_q   <= 1'b0;
            uflow_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            byte_q   <= byte_d;
            last_q   <= last_d;
            octets_q <= octets_d;
            crc_q    <= crc_d;
            tx_d_q   <= tx_d_d;
            tx_en_q  <= tx_en_d;
            tx_er_q  <= tx_er_d;
            done_q   <= done_d;
            uflow_q  <= uflow_d;
        end
    end

    assign o_tx_ready   = tx_ready;
    assign o_mii_tx_d   = tx_d_q;
    assign o_mii_tx_en  = tx_en_q;
    assign o_mii_tx_er  = tx_er_q;
    assign o_busy       = (state_q != StIdle);
    assign o_frame_done = done_q;
    assign o_underflow  = uflow_q;

endmodule
